// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: pipeline request/response and SRAM port signals of the arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic [15:0]       if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              mem_rd;
  logic              mem_wr;
  logic [15:0]       mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              busy;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_drive;
  logic              ram_ce_n;
  logic              ram_oe_n;
  logic              ram_we_n;
  modport slave (
    input  if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, ram_rdata,
    output if_rdata, if_ready, mem_rdata, mem_ready, busy,
           ram_addr, ram_wdata, ram_drive, ram_ce_n, ram_oe_n, ram_we_n
  );
  modport master (
    output if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, ram_rdata,
    input  if_rdata, if_ready, mem_rdata, mem_ready, busy,
           ram_addr, ram_wdata, ram_drive, ram_ce_n, ram_oe_n, ram_we_n
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: serializes IF fetches and MEM loads/stores onto one SRAM port with wait states
module mem_arbiter #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16,
  parameter int WAIT   = 1
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, RESP} state_t;
  state_t     state, state_n;
  logic [2:0] cnt;
  logic       owner_mem;
  logic       last_mem;
  logic       grant_mem;
  logic       grant_if;
  logic       last_cyc;
  always_comb begin
    grant_mem = (bus.mem_rd || bus.mem_wr) && !(last_mem && bus.if_req);
    grant_if  = bus.if_req && !grant_mem;
    last_cyc  = cnt == 3'(WAIT);
    state_n   = state == IDLE     ? (grant_mem ? (bus.mem_wr ? WR_SETUP : RD) : grant_if ? RD : IDLE) :
                state == WR_SETUP ? WR_PULSE :
                state == RESP     ? IDLE :
                last_cyc          ? RESP : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= 3'd0;
      owner_mem     <= 1'b0;
      last_mem      <= 1'b0;
      bus.ram_addr  <= ADDR_W'(0);
      bus.ram_wdata <= DATA_W'(0);
      bus.if_rdata  <= DATA_W'(0);
      bus.mem_rdata <= DATA_W'(0);
      bus.if_ready  <= 1'b0;
      bus.mem_ready <= 1'b0;
      bus.busy      <= 1'b0;
      bus.ram_drive <= 1'b0;
      bus.ram_ce_n  <= 1'b1;
      bus.ram_oe_n  <= 1'b1;
      bus.ram_we_n  <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= state_n == state ? cnt + 3'd1 : 3'd0;
      if (state == IDLE && (grant_mem || grant_if)) begin
        owner_mem    <= grant_mem;
        last_mem     <= grant_mem;
        bus.ram_addr <= ADDR_W'(grant_mem ? bus.mem_addr : bus.if_addr);
        if (grant_mem && bus.mem_wr) bus.ram_wdata <= bus.mem_wdata;
      end
      if (state == RD && last_cyc && owner_mem) bus.mem_rdata <= bus.ram_rdata;
      if (state == RD && last_cyc && !owner_mem) bus.if_rdata <= bus.ram_rdata;
      bus.if_ready  <= state_n == RESP && !owner_mem;
      bus.mem_ready <= state_n == RESP && owner_mem;
      bus.busy      <= state_n != IDLE;
      bus.ram_drive <= state_n == WR_SETUP || state_n == WR_PULSE;
      bus.ram_ce_n  <= !(state_n == RD || state_n == WR_SETUP || state_n == WR_PULSE);
      bus.ram_oe_n  <= state_n != RD;
      bus.ram_we_n  <= state_n != WR_PULSE;
    end
  end
endmodule
